// File: rtl/key_expander.sv
// AES key schedule: expands a 128/192/256-bit key to 44/52/60 words, one word
// per cycle, then serves 128-bit round keys indexed by a consumer-driven counter.
// Ports: clk, rst_n (async, active-low); key_i (left-aligned key), mode_i
//   (0=NOOP, 1=ENC_128, 2=ENC_192, 3=ENC_256), key_load_i, rk_next_i,
//   rk_restart_i in; busy_o, keys_rdy_o, rk_o, rk_idx_o, rk_last_o out.

// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Ports: a in (byte), y out (substituted byte).
module bsbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] sq;
  logic [7:0] inv;

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] xa;
    logic [7:0] zb;
    p  = 8'h00;
    xa = x;
    zb = z;
    for (int k = 0; k < 8; k++) begin
      if (zb[0]) p = p ^ xa;
      zb = zb >> 1;
      xa = {xa[6:0], 1'b0} ^ (xa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^-1 (and maps 0 to 0): product of a^2, a^4, ..., a^128
  always_comb begin
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module key_expander #(
  parameter int MAX_WORDS      = 60,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key_i,
  input  logic [1:0]   mode_i,
  input  logic         key_load_i,
  input  logic         rk_next_i,
  input  logic         rk_restart_i,
  output logic         busy_o,
  output logic         keys_rdy_o,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_last_o
);
  localparam int AW = $clog2(MAX_WORDS);
  localparam logic [1:0] MODE_NOOP = 2'd0;
  localparam logic [1:0] MODE_192  = 2'd2;
  localparam logic [1:0] MODE_256  = 2'd3;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  state_t state;

  logic [AW-1:0] wi;       // index of the word being generated
  logic [AW-1:0] nk;       // latched Nk
  logic [AW-1:0] t_last;   // latched T-1
  logic [3:0]    nr;       // latched Nr
  logic [2:0]    kpos;     // wi mod Nk, tracked incrementally to avoid a divider
  logic [7:0]    rcon;     // Rcon[wi/Nk], advanced each time kpos wraps
  logic [31:0]   store [MAX_WORDS];

  logic          load_ok;
  logic [AW-1:0] nk_new;
  logic [AW-1:0] tl_new;
  logic [3:0]    nr_new;

  assign load_ok = (state != EXPAND) && key_load_i && (mode_i != MODE_NOOP);

  always_comb begin
    nk_new = AW'(4);
    tl_new = AW'(43);
    nr_new = 4'd10;
    case (mode_i)
      MODE_192: begin nk_new = AW'(6); tl_new = AW'(51); nr_new = 4'd12; end
      MODE_256: begin nk_new = AW'(8); tl_new = AW'(59); nr_new = 4'd14; end
      default:  ;
    endcase
  end

  // Next-word datapath: one SubWord per cycle through four shared S-boxes
  logic [31:0] prev;
  logic [31:0] back;
  logic [31:0] sb_in;
  logic [31:0] sb_out;
  logic [31:0] tmp;
  logic [31:0] new_word;
  logic        is_rcon;
  logic        is_sub8;

  assign prev    = store[wi - AW'(1)];
  assign back    = store[wi - nk];
  assign is_rcon = (kpos == 3'd0);
  assign is_sub8 = (nk == AW'(8)) && (kpos == 3'd4);
  assign sb_in   = is_rcon ? {prev[23:0], prev[31:24]} : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    bsbox u_sbox (.a(sb_in[8*b +: 8]), .y(sb_out[8*b +: 8]));
  end

  always_comb begin
    tmp = prev;
    if (is_rcon)      tmp = sb_out ^ {rcon, 24'h0};
    else if (is_sub8) tmp = sb_out;
    new_word = back ^ tmp;
  end

  // Word store: a load writes w[0..Nk-1] in one edge, expansion writes w[wi]
  for (genvar j = 0; j < MAX_WORDS; j++) begin : g_word
    localparam int KJ = (j < 8) ? j : 0;
    logic        we;
    logic [31:0] wd;
    logic [31:0] q;

    always_comb begin
      we = 1'b0;
      wd = new_word;
      if (load_ok) begin
        if ((j < 8) && (AW'(j) < nk_new)) begin
          we = 1'b1;
          wd = key_i[255-32*KJ -: 32];
        end
      end else if ((state == EXPAND) && (wi == AW'(j))) begin
        we = 1'b1;
      end
    end

    if (CLEAR_ON_RESET) begin : g_clr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= 32'h0;
        else if (we) q <= wd;
      end
    end else begin : g_noclr
      always_ff @(posedge clk) begin
        if (we) q <= wd;
      end
    end

    assign store[j] = q;
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      keys_rdy_o <= 1'b0;
      rk_idx_o   <= 4'd0;
      rk_last_o  <= 1'b0;
      wi         <= '0;
      nk         <= AW'(4);
      t_last     <= AW'(43);
      nr         <= 4'd10;
      kpos       <= 3'd0;
      rcon       <= 8'h01;
    end else if (load_ok) begin
      state      <= EXPAND;
      busy_o     <= 1'b1;
      keys_rdy_o <= 1'b0;
      rk_idx_o   <= 4'd0;
      rk_last_o  <= 1'b0;
      wi         <= nk_new;
      nk         <= nk_new;
      t_last     <= tl_new;
      nr         <= nr_new;
      kpos       <= 3'd0;
      rcon       <= 8'h01;
    end else begin
      case (state)
        EXPAND: begin
          wi   <= wi + AW'(1);
          kpos <= (AW'(kpos) == nk - AW'(1)) ? 3'd0 : kpos + 3'd1;
          if (is_rcon) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (wi == t_last) begin
            state      <= READY;
            busy_o     <= 1'b0;
            keys_rdy_o <= 1'b1;
          end
        end
        READY: begin
          if (rk_restart_i) begin
            rk_idx_o  <= 4'd0;
            rk_last_o <= 1'b0;
          end else if (rk_next_i) begin
            if (rk_idx_o == nr) begin
              rk_idx_o  <= 4'd0;
              rk_last_o <= 1'b0;
            end else begin
              rk_idx_o  <= rk_idx_o + 4'd1;
              rk_last_o <= (rk_idx_o + 4'd1 == nr);
            end
          end
        end
        IDLE:    ;
        default: state <= IDLE;
      endcase
    end
  end

  // Round key is read straight from the store so it is valid with the index
  logic [AW-1:0] rk_base;
  assign rk_base = AW'({rk_idx_o, 2'b00});

  always_comb begin
    rk_o = '0;
    if (keys_rdy_o)
      rk_o = {store[rk_base], store[rk_base + AW'(1)],
              store[rk_base + AW'(2)], store[rk_base + AW'(3)]};
  end
endmodule

// File: tb/tb_key_expander.sv
module tb_key_expander;
  localparam logic [1:0] M_NOOP = 2'd0, M_128 = 2'd1, M_192 = 2'd2, M_256 = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key;
  logic [1:0]   mode;
  logic         key_load, rk_next, rk_restart;
  logic         busy, keys_rdy, rk_last;
  logic [127:0] rk;
  logic [3:0]   rk_idx;

  always #5 clk = ~clk;

  key_expander dut (
    .clk(clk), .rst_n(rst_n), .key_i(key), .mode_i(mode),
    .key_load_i(key_load), .rk_next_i(rk_next), .rk_restart_i(rk_restart),
    .busy_o(busy), .keys_rdy_o(keys_rdy), .rk_o(rk), .rk_idx_o(rk_idx),
    .rk_last_o(rk_last)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sbox_t [256];
  logic [7:0]  rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] mw [60];
  int          m_nk, m_nr;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 9'h11b;
    end
    return acc[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k, input logic [1:0] m);
    logic [31:0] t;
    m_nk = (m == M_128) ? 4 : (m == M_192) ? 6 : 8;
    m_nr = m_nk + 6;
    for (int i = 0; i < m_nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
      t = mw[i-1];
      if (i % m_nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/m_nk - 1], 24'h0};
      else if (m_nk == 8 && i % 8 == 4) t = subw(t);
      mw[i] = mw[i-m_nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [255:0] k, input logic [1:0] m);
    key = k;
    mode = m;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    mode = 2'($urandom);   // must be ignored once latched
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!keys_rdy && n < 200) begin
      step();
      n++;
    end
  endtask

  // Walk every round key, then confirm the index wraps to 0
  task automatic check_schedule(input string tag);
    for (int r = 0; r <= m_nr; r++) begin
      check({tag, "_rk"}, rk, model_rk(r));
      check({tag, "_idx"}, 128'(rk_idx), 128'(r));
      check({tag, "_last"}, 128'(rk_last), 128'(r == m_nr));
      rk_next = 1'b1;
      step();
      rk_next = 1'b0;
    end
    check({tag, "_wrap"}, 128'(rk_idx), 128'd0);
  endtask

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    int n;
    int midx;
    logic [1:0] rm;
    logic [255:0] rkey;
    rst_n = 1'b0;
    key = '0;
    mode = M_NOOP;
    key_load = 1'b0;
    rk_next = 1'b0;
    rk_restart = 1'b0;
    build_sbox();
    #12;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rdy", 128'(keys_rdy), 128'd0);
    check("rst_idx", 128'(rk_idx), 128'd0);
    check("rst_last", 128'(rk_last), 128'd0);
    check("rst_rk", rk, 128'd0);
    rst_n = 1'b1;
    step();

    // AES-128 reference vector
    do_load(K128, M_128);
    model_expand(K128, M_128);
    check("a128_busy", 128'(busy), 128'd1);
    wait_rdy(n);
    check("a128_lat", 128'(n), 128'd40);
    check("a128_busy_done", 128'(busy), 128'd0);
    check("a128_r0", rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rk_next = 1'b1;
    step();
    check("a128_w4", 128'(rk[127:96]), 128'h00000000_00000000_00000000_a0fafe17);
    repeat (9) step();
    rk_next = 1'b0;
    check("a128_r10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("a128_last", 128'(rk_last), 128'd1);
    rk_next = 1'b1;
    step();
    rk_next = 1'b0;
    check("a128_wrap", 128'(rk_idx), 128'd0);
    check_schedule("a128");

    // next + restart together -> 0
    rk_next = 1'b1;
    repeat (3) step();
    rk_restart = 1'b1;
    step();
    rk_next = 1'b0;
    rk_restart = 1'b0;
    check("next_restart", 128'(rk_idx), 128'd0);

    // NOOP load in READY is ignored
    key = K256;
    mode = M_NOOP;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    check("noop_busy", 128'(busy), 128'd0);
    check("noop_rdy", 128'(keys_rdy), 128'd1);
    check("noop_rk", rk, model_rk(0));

    // Load and rk_next during EXPAND are ignored
    do_load(K128, M_128);
    for (int c = 0; c < 5; c++) begin
      key = K256;
      mode = M_256;
      key_load = 1'b1;
      rk_next = 1'b1;
      step();
      check("exp_idx", 128'(rk_idx), 128'd0);
      check("exp_busy", 128'(busy), 128'd1);
    end
    key_load = 1'b0;
    rk_next = 1'b0;
    wait_rdy(n);
    check("exp_lat", 128'(n + 5), 128'd40);
    check_schedule("exp");

    // Asynchronous reset mid-expansion
    do_load(K192, M_192);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_rdy", 128'(keys_rdy), 128'd0);
    check("arst_idx", 128'(rk_idx), 128'd0);
    check("arst_rk", rk, 128'd0);
    #3;
    rst_n = 1'b1;
    step();
    do_load(K128, M_128);
    wait_rdy(n);
    check("post_rst_lat", 128'(n), 128'd40);
    check_schedule("post_rst");

    // AES-192 reference vector
    do_load(K192, M_192);
    check("a192_drop", 128'(keys_rdy), 128'd0);
    model_expand(K192, M_192);
    wait_rdy(n);
    check("a192_lat", 128'(n), 128'd46);
    rk_next = 1'b1;
    repeat (12) step();
    rk_next = 1'b0;
    check("a192_r12w3", 128'(rk[31:0]), 128'h01002202);
    check("a192_last", 128'(rk_last), 128'd1);
    rk_restart = 1'b1;
    step();
    rk_restart = 1'b0;
    check_schedule("a192");

    // AES-256 reference vector
    do_load(K256, M_256);
    model_expand(K256, M_256);
    wait_rdy(n);
    check("a256_lat", 128'(n), 128'd52);
    rk_next = 1'b1;
    repeat (14) step();
    rk_next = 1'b0;
    check("a256_r14", rk, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    rk_restart = 1'b1;
    step();
    rk_restart = 1'b0;
    check_schedule("a256");

    // Random keys/modes reloaded from READY, then random index traffic
    for (int it = 0; it < 6; it++) begin
      rm = 2'($urandom_range(1, 3));
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_load(rkey, rm);
      check("rnd_drop", 128'(keys_rdy), 128'd0);
      model_expand(rkey, rm);
      wait_rdy(n);
      check("rnd_lat", 128'(n), 128'(4 * (m_nr + 1) - m_nk));
      midx = 0;
      for (int c = 0; c < 40; c++) begin
        check("rnd_rk", rk, model_rk(midx));
        check("rnd_idx", 128'(rk_idx), 128'(midx));
        check("rnd_last", 128'(rk_last), 128'(midx == m_nr));
        rk_next = 1'($urandom_range(0, 1));
        rk_restart = ($urandom_range(0, 7) == 0);
        key_load = ($urandom_range(0, 7) == 0);
        mode = M_NOOP;
        step();
        if (rk_restart) midx = 0;
        else if (rk_next) midx = (midx == m_nr) ? 0 : midx + 1;
        rk_next = 1'b0;
        rk_restart = 1'b0;
        key_load = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
